// File: rtl/mem_if.sv
// Data-bus interface between the memory-access stage and the single-port
// data memory. The stage is the master and raises bus_req until bus_ack.
interface mem_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/mem.sv
// Memory-access stage of the five-stage core. Loads and stores coming from
// ex are issued on the single-port data bus (req/ack handshake) while the
// pipeline is stalled; ALU results and extended load data are forwarded to
// the register file.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses are dropped and flagged on
//               misalign_o for one cycle.
//   undefined - misalign_o does not exist; the low address bits that do not
//               matter for the access size are forced to zero.
module mem (
    input  logic        clk,
    input  logic        rst,
    output logic        stall,
    input  logic        valid_i,
    input  logic        mem_ren,
    input  logic        mem_wena,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic        gprs_wena_i,
    input  logic [4:0]  gprs_waddr_i,
    input  logic [31:0] gprs_wdata_i,
    mem_if.master       bus,
    output logic        gprs_wena_o,
    output logic [4:0]  gprs_waddr_o,
    output logic [31:0] gprs_wdata_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_o
`endif
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state_q, state_d;

    logic        busReq_q, busReq_d;
    logic        busWe_q, busWe_d;
    logic [31:0] busAddr_q, busAddr_d;
    logic [3:0]  busBe_q, busBe_d;
    logic [31:0] busWdata_q, busWdata_d;

    logic [1:0]  offset_q, offset_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [4:0]  destAddr_q, destAddr_d;
    logic        destWena_q, destWena_d;

    logic        gprsWena_q, gprsWena_d;
    logic [4:0]  gprsWaddr_q, gprsWaddr_d;
    logic [31:0] gprsWdata_q, gprsWdata_d;

    logic        memOp;
    logic        issue;
    logic [1:0]  effOff;
    logic [3:0]  issueBe;
    logic [31:0] issueWdata;
    logic [31:0] rdataShifted;
    logic [31:0] loadData;

`ifdef MEM_MISALIGN_TRAP_EN
    logic        misaligned;
    logic        misalign_q, misalign_d;
`endif

    // Decode the incoming bundle: effective lane offset, byte enables and
    // lane-replicated store data for the request about to be issued.
    always_comb begin
        memOp = valid_i & (mem_ren | mem_wena);
        case (mem_size)
            SIZE_BYTE: begin
                effOff     = mem_addr[1:0];
                issueBe    = 4'b0001 << mem_addr[1:0];
                issueWdata = {4{mem_wdata[7:0]}};
            end
            SIZE_HALF: begin
                effOff     = {mem_addr[1], 1'b0};
                issueBe    = 4'b0011 << {mem_addr[1], 1'b0};
                issueWdata = {2{mem_wdata[15:0]}};
            end
            default: begin
                effOff     = 2'b00;
                issueBe    = 4'hF;
                issueWdata = mem_wdata;
            end
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = ((mem_size == SIZE_HALF) & mem_addr[0]) |
                     (mem_size[1] & (mem_addr[1:0] != 2'b00));
        issue      = memOp & ~misaligned;
`else
        issue      = memOp;
`endif
    end

    // Pull the addressed lanes out of the returned word and extend them.
    always_comb begin
        rdataShifted = bus.bus_rdata >> {offset_q, 3'b000};
        case (size_q)
            SIZE_BYTE: loadData = unsigned_q ? {24'h0, rdataShifted[7:0]}
                                             : {{24{rdataShifted[7]}}, rdataShifted[7:0]};
            SIZE_HALF: loadData = unsigned_q ? {16'h0, rdataShifted[15:0]}
                                             : {{16{rdataShifted[15]}}, rdataShifted[15:0]};
            default:   loadData = rdataShifted;
        endcase
    end

    // Next-state and output logic: everything holds unless the current
    // state/event says otherwise; stall is only raised while an access is
    // being issued or is still waiting for its acknowledge.
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        busReq_d    = busReq_q;
        busWe_d     = busWe_q;
        busAddr_d   = busAddr_q;
        busBe_d     = busBe_q;
        busWdata_d  = busWdata_q;
        offset_d    = offset_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        destAddr_d  = destAddr_q;
        destWena_d  = destWena_q;
        gprsWena_d  = gprsWena_q;
        gprsWaddr_d = gprsWaddr_q;
        gprsWdata_d = gprsWdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (issue) begin
                    stall      = 1'b1;
                    state_d    = BUSY;
                    busReq_d   = 1'b1;
                    busWe_d    = mem_wena;
                    busAddr_d  = {mem_addr[31:2], 2'b00};
                    busBe_d    = issueBe;
                    busWdata_d = issueWdata;
                    offset_d   = effOff;
                    size_d     = mem_size;
                    unsigned_d = mem_unsigned;
                    destAddr_d = gprs_waddr_i;
                    destWena_d = gprs_wena_i;
                    gprsWena_d = 1'b0;
                end
`ifdef MEM_MISALIGN_TRAP_EN
                else if (memOp) begin
                    misalign_d = 1'b1;
                    gprsWena_d = 1'b0;
                end
`endif
                else begin
                    gprsWena_d  = valid_i & gprs_wena_i;
                    gprsWaddr_d = gprs_waddr_i;
                    gprsWdata_d = gprs_wdata_i;
                end
            end
            BUSY: begin
                if (bus.bus_ack) begin
                    state_d  = IDLE;
                    busReq_d = 1'b0;
                    if (busWe_q) begin
                        gprsWena_d = 1'b0;
                    end else begin
                        gprsWena_d  = destWena_q;
                        gprsWaddr_d = destAddr_q;
                        gprsWdata_d = loadData;
                    end
                end else begin
                    stall      = 1'b1;
                    gprsWena_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                busReq_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busReq_q    <= 1'b0;
            busWe_q     <= 1'b0;
            busAddr_q   <= 32'h0;
            busBe_q     <= 4'h0;
            busWdata_q  <= 32'h0;
            offset_q    <= 2'b00;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            destAddr_q  <= 5'h0;
            destWena_q  <= 1'b0;
            gprsWena_q  <= 1'b0;
            gprsWaddr_q <= 5'h0;
            gprsWdata_q <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busReq_q    <= busReq_d;
            busWe_q     <= busWe_d;
            busAddr_q   <= busAddr_d;
            busBe_q     <= busBe_d;
            busWdata_q  <= busWdata_d;
            offset_q    <= offset_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            destAddr_q  <= destAddr_d;
            destWena_q  <= destWena_d;
            gprsWena_q  <= gprsWena_d;
            gprsWaddr_q <= gprsWaddr_d;
            gprsWdata_q <= gprsWdata_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign bus.bus_req   = busReq_q;
    assign bus.bus_we    = busWe_q;
    assign bus.bus_addr  = busAddr_q;
    assign bus.bus_be    = busBe_q;
    assign bus.bus_wdata = busWdata_q;
    assign gprs_wena_o   = gprsWena_q;
    assign gprs_waddr_o  = gprsWaddr_q;
    assign gprs_wdata_o  = gprsWdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_o    = misalign_q;
`endif

endmodule
